uart_rx_cfg: RTL and testbench
==============================

# uart_rx_cfg

Parametrised UART receiver: a configurable successor to the fixed 8N1 receiver. Data width, parity mode and stop-bit count are build-time parameters. The block samples each bit at its centre, rejects false starts, and reports parity and framing errors per word. Received words go to the consumer through a one-deep valid/ready holding register, with overrun detection and RTS flow control. It sits between the synchronised `rxd` pin and the host-side byte consumer.

## Interface
- `CLKS_PER_BIT`, 87: clk cycles per bit period; must be ≥ 4.
- `DATA_BITS`, 8: data bits per frame, legal range 5..9.
- `PARITY`, 0: parity mode; 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, 1: stop bits per frame, 1 or 2.
- `clk`  in  1  sole clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `rxd`  in  1  asynchronous serial line; idles high.
- `rx_data`  out  DATA_BITS  received word, LSB = first data bit on the line.
- `rx_valid`  out  1  holding register contains a word.
- `rx_ready`  in  1  consumer accepts the word when `rx_valid && rx_ready`.
- `parity_err`  out  1  parity mismatch for the held word; always 0 when PARITY = 0.
- `frame_err`  out  1  at least one stop bit of the held word sampled 0.
- `overrun`  out  1  one-cycle pulse: a completed word was dropped because the holding register was full.
- `rts`  out  1  equals `!rx_valid`; high means ready for more data.
- `busy`  out  1  high while the FSM is in any state other than IDLE.

## Operation
- `rxd` passes through a 2-flop synchroniser (both flops reset to 1), giving `rxs`. A third flop holds `rxs_d` for falling-edge detection.
- Bit counter `cnt` is `$clog2(CLKS_PER_BIT)` bits wide; `HALF = CLKS_PER_BIT/2` (integer division).
- The data shift register shifts in from the MSB, so that after DATA_BITS shifts the first data bit is at bit 0.
- FSM states and transitions:
  - IDLE: go to START on a falling edge (`rxs_d == 1 && rxs == 0`), with `cnt` = 0. A line held low does not re-arm; a high level is required first.
  - START: increment `cnt`. At `cnt == HALF-1`:
    - `rxs == 1` is a false start; go to IDLE with no output.
    - `rxs == 0` goes to DATA with `cnt` = 0 and the bit index = 0.
  - DATA: sample at `cnt == CLKS_PER_BIT-1`, shift `rxs` in, reset `cnt` to 0 and increment the index. After the DATA_BITS-th sample, go to PAR if PARITY ≠ 0, otherwise to STOP.
  - PAR: one sample at `cnt == CLKS_PER_BIT-1`.
    - Odd parity: error if the XOR of data and the parity bit is 0.
    - Even parity: error if that XOR is 1.
    - Go to STOP.
  - STOP: sample STOP_BITS times, one bit period apart. Any 0 sample sets the internal frame flag. At the last stop sample, perform the completion step and go to IDLE in the same edge, so a start bit arriving right after mid-stop is caught.
- Completion step, evaluated on the edge of the final stop sample:
  - If `!rx_valid || rx_ready`: load `rx_data`, `parity_err` and `frame_err`, and set `rx_valid` = 1.
  - Otherwise: discard the word, keep the held word unchanged, and pulse `overrun` for 1 cycle.
- Handshake:
  - `rx_valid` falls on the edge where `rx_valid && rx_ready` is true, unless a completion happens on the same edge. In that case the new word loads and `rx_valid` stays 1.
  - The error flags are qualified by `rx_valid` and change only on a load.
- Reset, effective on the next edge, also mid-frame:
  - FSM goes to IDLE, `cnt` = 0, index = 0, synchroniser = 1.
  - `rx_data` = 0, `rx_valid` = 0, `parity_err` = 0, `frame_err` = 0, `overrun` = 0, `busy` = 0, `rts` = 1.
  - Any partial frame is discarded. If `rxd` is low when reset is released, that is not a start; reception waits for a high-to-low edge.

## Timing
- Let edge E be the first clk edge at which `rxs` = 0 with `rxs_d` = 1. E is 2–3 cycles after the `rxd` transition.
- The start validity check is at E + HALF.
- Data bit k (counting from 0) is sampled at E + HALF + (k+1)·CLKS_PER_BIT.
- With N = DATA_BITS + (PARITY≠0) + STOP_BITS, the final stop sample and the `rx_valid` / `overrun` update happen at E + HALF + N·CLKS_PER_BIT. The outputs are visible in the following cycle.
- `busy` rises the cycle after E and falls the cycle after the final stop sample.
- `rts` follows `rx_valid` combinationally, with no added latency.
- Back-to-back frames with zero idle gap are received without loss, provided the consumer accepts each word within one frame time.

## Test plan
- 8N1, CLKS_PER_BIT=16: send 0xA5 → `rx_data`=0xA5, `rx_valid`=1 at the cycle given under Timing, both error flags 0. Then `rx_ready`=1 for one cycle → `rx_valid`=0 and `rts`=1.
- 7E1: send 0x35 with parity bit 0 → `parity_err`=0. Send 0x35 with parity bit 1 → `parity_err`=1 and `rx_data`=0x35.
- 8N2: stop bit 2 forced to 0 → `frame_err`=1, word still delivered. Hold the line low afterwards → no further frame until the line returns high and then falls.
- False start: `rxd` low for HALF-3 cycles, then high → `busy` pulses, no `rx_valid`, FSM back in IDLE.
- Overrun: send 0x11 then 0x22 with `rx_ready`=0 → `rx_data` stays 0x11 and `overrun` pulses once at the 0x22 completion. Repeat with `rx_ready`=1 on the exact completion cycle → 0x22 loads, `rx_valid` stays 1, no overrun.
- Assert `rst` during bit 4 of a frame → all outputs return to their reset values next cycle. The following clean frame 0x5A is received correctly.

Source files
------------

// File: rtl/uart_rx_cfg.sv
// -----------------------------------------------------------------------------
// uart_rx_cfg
//
// Parametrised UART receiver. Data width, parity mode and stop-bit count are
// fixed at build time. Each bit is sampled at its centre, false starts are
// rejected, and parity/framing errors are reported per word. Completed words
// are handed to the consumer through a one-deep valid/ready holding register.
// If a word completes while that register is still full, the new word is
// dropped and `overrun` pulses.
//
// Parameters
//   CLKS_PER_BIT  clk cycles per bit period (>= 4)
//   DATA_BITS     data bits per frame (5..9)
//   PARITY        0 = none, 1 = odd, 2 = even
//   STOP_BITS     stop bits per frame (1 or 2)
//
// Ports
//   clk         sole clock, rising edge
//   rst         synchronous active-high reset
//   rxd         asynchronous serial input, idles high
//   rx_data     held word, LSB = first data bit on the line
//   rx_valid    holding register contains a word
//   rx_ready    consumer takes the word when rx_valid && rx_ready
//   parity_err  parity mismatch for the held word (0 when PARITY = 0)
//   frame_err   a stop bit of the held word sampled 0
//   overrun     one-cycle pulse: completed word dropped, register was full
//   rts         !rx_valid; high means ready for more data
//   busy        receiver FSM is not idle
// -----------------------------------------------------------------------------
module uart_rx_cfg #(
  parameter int CLKS_PER_BIT = 87,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 rts,
  output logic                 busy
);

  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int IW   = $clog2(DATA_BITS + 1);

  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_MID  = CW'(HALF - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PAR,
    S_STOP
  } state_e;

  // Input synchroniser plus one delay flop for falling-edge detection.
  logic sync_meta_q, rxs_q, rxs_dly_q;

  // After reset the synchroniser holds reset values rather than line samples.
  // Edge detection is held off until all three flops carry real samples, so a
  // line that is already low at reset release does not look like a start bit.
  logic [1:0] settle_q, settle_d;

  state_e                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   par_acc_q, par_acc_d;
  logic                   frame_acc_q, frame_acc_d;
  logic                   stop_idx_q, stop_idx_d;

  logic [DATA_BITS-1:0]   rx_data_q, rx_data_d;
  logic                   rx_valid_q, rx_valid_d;
  logic                   parity_err_q, parity_err_d;
  logic                   frame_err_q, frame_err_d;
  logic                   overrun_q, overrun_d;

  logic fall_edge;
  logic bit_tick;
  logic complete;
  logic par_xor;

  assign fall_edge = (settle_q == 2'd3) && rxs_dly_q && !rxs_q;
  assign bit_tick  = (cnt_q == CNT_LAST);
  assign par_xor   = (^shift_q) ^ rxs_q;

  // NOTE: every signal assigned in this block gets a default first; a path
  // that leaves one unassigned would infer a latch.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    shift_d      = shift_q;
    par_acc_d    = par_acc_q;
    frame_acc_d  = frame_acc_q;
    stop_idx_d   = stop_idx_q;
    settle_d     = (settle_q == 2'd3) ? settle_q : settle_q + 2'd1;
    rx_data_d    = rx_data_q;
    rx_valid_d   = rx_valid_q;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;
    overrun_d    = 1'b0;
    complete     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        if (fall_edge) begin
          state_d     = S_START;
          par_acc_d   = 1'b0;
          frame_acc_d = 1'b0;
          stop_idx_d  = 1'b0;
        end
      end

      S_START: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_MID) begin
          cnt_d   = '0;
          idx_d   = '0;
          // Line back high at mid start bit: glitch, not a frame.
          state_d = rxs_q ? S_IDLE : S_DATA;
        end
      end

      S_DATA: begin
        cnt_d = cnt_q + 1'b1;
        if (bit_tick) begin
          cnt_d   = '0;
          // Shift in from the MSB so the first bit ends up at bit 0.
          shift_d = {rxs_q, shift_q[DATA_BITS-1:1]};
          idx_d   = idx_q + 1'b1;
          if (idx_q == IDX_LAST) state_d = (PARITY != 0) ? S_PAR : S_STOP;
        end
      end

      S_PAR: begin
        cnt_d = cnt_q + 1'b1;
        if (bit_tick) begin
          cnt_d     = '0;
          par_acc_d = (PARITY == 1) ? !par_xor : par_xor;
          state_d   = S_STOP;
        end
      end

      S_STOP: begin
        cnt_d = cnt_q + 1'b1;
        if (bit_tick) begin
          cnt_d       = '0;
          frame_acc_d = frame_acc_q | !rxs_q;
          stop_idx_d  = 1'b1;
          // Leave STOP at mid-bit so a start bit right behind it is caught.
          if (stop_idx_q == STOP_LAST) begin
            complete = 1'b1;
            state_d  = S_IDLE;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Handshake: consumption clears the register unless a new word lands on
    // the same edge, in which case the load below keeps it valid.
    if (rx_valid_q && rx_ready) rx_valid_d = 1'b0;

    if (complete) begin
      if (!rx_valid_q || rx_ready) begin
        rx_data_d    = shift_q;
        parity_err_d = (PARITY != 0) && par_acc_q;
        frame_err_d  = frame_acc_q | !rxs_q;
        rx_valid_d   = 1'b1;
      end else begin
        overrun_d    = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_meta_q  <= 1'b1;
      rxs_q        <= 1'b1;
      rxs_dly_q    <= 1'b1;
      settle_q     <= 2'd0;
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      idx_q        <= '0;
      shift_q      <= '0;
      par_acc_q    <= 1'b0;
      frame_acc_q  <= 1'b0;
      stop_idx_q   <= 1'b0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      sync_meta_q  <= rxd;
      rxs_q        <= sync_meta_q;
      rxs_dly_q    <= rxs_q;
      settle_q     <= settle_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      shift_q      <= shift_d;
      par_acc_q    <= par_acc_d;
      frame_acc_q  <= frame_acc_d;
      stop_idx_q   <= stop_idx_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
    end
  end

  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;
  assign rts        = !rx_valid_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_cfg.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_cfg
//
// Three receivers share clk/rst: channel 0 is 8N1, channel 1 is 7E1 and
// channel 2 is 8N2, all at 16 clocks per bit. Frames are driven bit by bit on
// the falling clock edge and outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_uart_rx_cfg;

  localparam int CPB  = 16;
  localparam int HALF = CPB / 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [2:0] rxd_v, rdy_v, val_v, perr_v, ferr_v, ovr_v, rts_v, busy_v;
  logic [7:0] d0;
  logic [6:0] d1;
  logic [7:0] d2;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int ovr_cnt  [3];
  int busy_cnt [3];

  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
    .clk(clk), .rst(rst), .rxd(rxd_v[0]), .rx_data(d0), .rx_valid(val_v[0]),
    .rx_ready(rdy_v[0]), .parity_err(perr_v[0]), .frame_err(ferr_v[0]),
    .overrun(ovr_v[0]), .rts(rts_v[0]), .busy(busy_v[0]));

  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(2), .STOP_BITS(1)) u_7e1 (
    .clk(clk), .rst(rst), .rxd(rxd_v[1]), .rx_data(d1), .rx_valid(val_v[1]),
    .rx_ready(rdy_v[1]), .parity_err(perr_v[1]), .frame_err(ferr_v[1]),
    .overrun(ovr_v[1]), .rts(rts_v[1]), .busy(busy_v[1]));

  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) u_8n2 (
    .clk(clk), .rst(rst), .rxd(rxd_v[2]), .rx_data(d2), .rx_valid(val_v[2]),
    .rx_ready(rdy_v[2]), .parity_err(perr_v[2]), .frame_err(ferr_v[2]),
    .overrun(ovr_v[2]), .rts(rts_v[2]), .busy(busy_v[2]));

  // Cycle counter and event monitors.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int k = 0; k < 3; k++) begin
      if (ovr_v[k])  ovr_cnt[k]  <= ovr_cnt[k] + 1;
      if (busy_v[k]) busy_cnt[k] <= busy_cnt[k] + 1;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [8:0] dat(input int ch);
    case (ch)
      0:       return {1'b0, d0};
      1:       return {2'b0, d1};
      default: return {1'b0, d2};
    endcase
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_ready(input int ch);
    rdy_v[ch] = 1'b1;
    @(negedge clk);
    rdy_v[ch] = 1'b0;
  endtask

  // Drive one frame on channel ch; must be called at a falling edge.
  task automatic send_frame(input int ch, input logic [8:0] data, input int dbits,
                            input int pmode, input logic pbit,
                            input logic [1:0] stopv, input int nstop);
    logic [12:0] bits;
    int n;
    bits = '0;
    n = 0;
    bits[n] = 1'b0; n++;
    for (int k = 0; k < dbits; k++) begin bits[n] = data[k]; n++; end
    if (pmode != 0) begin bits[n] = pbit; n++; end
    for (int k = 0; k < nstop; k++) begin bits[n] = stopv[k]; n++; end
    for (int b = 0; b < n; b++) begin
      rxd_v[ch] = bits[b];
      repeat (CPB) @(negedge clk);
    end
  endtask

  task automatic check_reset_vals(input int ch);
    check($sformatf("rst_data%0d", ch),  dat(ch),    0);
    check($sformatf("rst_valid%0d", ch), val_v[ch],  0);
    check($sformatf("rst_perr%0d", ch),  perr_v[ch], 0);
    check($sformatf("rst_ferr%0d", ch),  ferr_v[ch], 0);
    check($sformatf("rst_ovr%0d", ch),   ovr_v[ch],  0);
    check($sformatf("rst_rts%0d", ch),   rts_v[ch],  1);
    check($sformatf("rst_busy%0d", ch),  busy_v[ch], 0);
  endtask

  typedef struct {
    logic [6:0] data;
    logic       pbit;
    logic       stop;
    logic       exp_perr;
    logic       exp_ferr;
  } vec_t;

  vec_t vecs [7];

  initial begin
    int c0, comp, b, o0, base, m_ovr;
    logic [6:0] m_data;
    logic m_valid, m_perr, m_ferr;

    // 7E1 vectors: {data, parity bit, stop bit, expected parity_err, expected frame_err}
    vecs[0] = '{7'h35, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{7'h35, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{7'h00, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{7'h7F, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{7'h7F, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[5] = '{7'h01, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[6] = '{7'h40, 1'b0, 1'b0, 1'b1, 1'b1};

    rst   = 1'b1;
    rxd_v = 3'b111;
    rdy_v = 3'b000;
    idle(3);
    rst = 1'b0;
    idle(5);
    for (int ch = 0; ch < 3; ch++) check_reset_vals(ch);

    // 8N1 0xA5 with exact timing of busy and rx_valid.
    fork
      send_frame(0, 9'hA5, 8, 0, 1'b0, 2'b11, 1);
      begin
        c0   = cyc;
        comp = c0 + 3 + HALF + 9 * CPB;
        while (cyc < c0 + 2) @(negedge clk);
        check("a5_busy_before_E", busy_v[0], 0);
        @(negedge clk);
        check("a5_busy_after_E", busy_v[0], 1);
        while (cyc < comp - 1) @(negedge clk);
        check("a5_valid_early", val_v[0], 0);
        check("a5_busy_late", busy_v[0], 1);
        @(negedge clk);
        check("a5_valid_on_time", val_v[0], 1);
        check("a5_busy_fall", busy_v[0], 0);
      end
    join
    check("a5_data", dat(0), 9'hA5);
    check("a5_perr", perr_v[0], 0);
    check("a5_ferr", ferr_v[0], 0);
    check("a5_rts", rts_v[0], 0);
    pulse_ready(0);
    check("a5_valid_drained", val_v[0], 0);
    check("a5_rts_drained", rts_v[0], 1);
    idle(4);

    // Back-to-back frames, zero idle gap, consumer drains early in frame 2.
    o0 = ovr_cnt[0];
    send_frame(0, 9'h3C, 8, 0, 1'b0, 2'b11, 1);
    check("b2b_data1", dat(0), 9'h3C);
    fork
      send_frame(0, 9'hC3, 8, 0, 1'b0, 2'b11, 1);
      begin
        idle(5);
        pulse_ready(0);
        check("b2b_mid_drained", val_v[0], 0);
      end
    join
    check("b2b_valid2", val_v[0], 1);
    check("b2b_data2", dat(0), 9'hC3);
    check("b2b_no_ovr", ovr_cnt[0], o0);
    pulse_ready(0);
    idle(4);

    // False start: low for HALF-3 cycles only.
    b = busy_cnt[0];
    rxd_v[0] = 1'b0;
    idle(HALF - 3);
    rxd_v[0] = 1'b1;
    idle(30);
    check("false_busy_cycles", busy_cnt[0] - b, HALF);
    check("false_no_valid", val_v[0], 0);
    check("false_idle", busy_v[0], 0);

    // Overrun: second word dropped while the first is held.
    send_frame(0, 9'h11, 8, 0, 1'b0, 2'b11, 1);
    check("ovr_first", dat(0), 9'h11);
    o0 = ovr_cnt[0];
    idle(2);
    send_frame(0, 9'h22, 8, 0, 1'b0, 2'b11, 1);
    check("ovr_held_data", dat(0), 9'h11);
    check("ovr_held_valid", val_v[0], 1);
    check("ovr_pulse_count", ovr_cnt[0] - o0, 1);
    idle(2);

    // Ready on the exact completion edge: new word loads, no overrun.
    fork
      send_frame(0, 9'h22, 8, 0, 1'b0, 2'b11, 1);
      begin
        c0   = cyc;
        comp = c0 + 3 + HALF + 9 * CPB;
        while (cyc < comp - 1) @(negedge clk);
        rdy_v[0] = 1'b1;
        @(negedge clk);
        rdy_v[0] = 1'b0;
        check("same_edge_valid", val_v[0], 1);
        check("same_edge_data", dat(0), 9'h22);
        check("same_edge_ovr", ovr_v[0], 0);
      end
    join
    check("same_edge_ovr_count", ovr_cnt[0] - o0, 1);
    idle(4);

    // 7E1 table.
    for (int i = 0; i < 7; i++) begin
      send_frame(1, {2'b0, vecs[i].data}, 7, 2, vecs[i].pbit, {1'b1, vecs[i].stop}, 1);
      check($sformatf("tab%0d_valid", i), val_v[1], 1);
      check($sformatf("tab%0d_data", i), dat(1), {2'b0, vecs[i].data});
      check($sformatf("tab%0d_perr", i), perr_v[1], vecs[i].exp_perr);
      check($sformatf("tab%0d_ferr", i), ferr_v[1], vecs[i].exp_ferr);
      pulse_ready(1);
      rxd_v[1] = 1'b1;
      idle(4);
    end

    // 8N2 with the second stop bit low, then the line held low.
    send_frame(2, 9'hC3, 8, 0, 1'b0, 2'b01, 2);
    check("n2_valid", val_v[2], 1);
    check("n2_data", dat(2), 9'hC3);
    check("n2_ferr", ferr_v[2], 1);
    check("n2_perr", perr_v[2], 0);
    pulse_ready(2);
    b = busy_cnt[2];
    idle(3 * 12 * CPB);
    check("n2_low_no_busy", busy_cnt[2] - b, 0);
    check("n2_low_no_valid", val_v[2], 0);
    rxd_v[2] = 1'b1;
    idle(10);
    send_frame(2, 9'h3C, 8, 0, 1'b0, 2'b11, 2);
    check("n2_next_data", dat(2), 9'h3C);
    check("n2_next_ferr", ferr_v[2], 0);
    check("n2_next_valid", val_v[2], 1);
    pulse_ready(2);

    // Randomised 7E1 traffic against a one-deep holding model.
    m_valid = 1'b0;
    m_data  = '0;
    m_perr  = 1'b0;
    m_ferr  = 1'b0;
    m_ovr   = 0;
    base    = ovr_cnt[1];
    for (int i = 0; i < 24; i++) begin
      logic [6:0] rd;
      logic rp, rs, consume;
      rd      = 7'($urandom_range(0, 127));
      rp      = 1'($urandom_range(0, 1));
      rs      = ($urandom_range(0, 5) != 0);
      consume = ($urandom_range(0, 3) != 0);
      send_frame(1, {2'b0, rd}, 7, 2, rp, {1'b1, rs}, 1);
      if (!m_valid) begin
        m_valid = 1'b1;
        m_data  = rd;
        m_perr  = (($countones(rd) + int'(rp)) % 2) != 0;
        m_ferr  = !rs;
      end else begin
        m_ovr++;
      end
      check($sformatf("rnd%0d_valid", i), val_v[1], m_valid);
      check($sformatf("rnd%0d_data", i), dat(1), {2'b0, m_data});
      check($sformatf("rnd%0d_perr", i), perr_v[1], m_perr);
      check($sformatf("rnd%0d_ferr", i), ferr_v[1], m_ferr);
      check($sformatf("rnd%0d_ovr", i), ovr_cnt[1] - base, m_ovr);
      if (consume) begin
        pulse_ready(1);
        m_valid = 1'b0;
        check($sformatf("rnd%0d_drain", i), val_v[1], 0);
      end
      rxd_v[1] = 1'b1;
      idle($urandom_range(3, 12));
    end

    // Reset during data bit 4 of a frame while a word is held on channel 0.
    check("pre_rst_valid", val_v[0], 1);
    rxd_v[0] = 1'b0;
    idle(CPB);
    for (int k = 0; k < 4; k++) begin
      rxd_v[0] = 1'b1;
      idle(CPB);
    end
    rxd_v[0] = 1'b0;
    idle(HALF);
    rst = 1'b1;
    @(negedge clk);
    check_reset_vals(0);
    rst = 1'b0;
    b = busy_cnt[0];
    idle(40);
    check("post_rst_low_no_busy", busy_cnt[0] - b, 0);
    check("post_rst_low_no_valid", val_v[0], 0);
    rxd_v[0] = 1'b1;
    idle(10);
    send_frame(0, 9'h5A, 8, 0, 1'b0, 2'b11, 1);
    check("post_rst_valid", val_v[0], 1);
    check("post_rst_data", dat(0), 9'h5A);
    check("post_rst_perr", perr_v[0], 0);
    check("post_rst_ferr", ferr_v[0], 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
